// File: rtl/icache_pkg.sv
// Shared widths, line geometry and FSM state encoding for the instruction cache.
package icache_pkg;
    localparam int   ADDR_W         = 32;
    localparam int   INSTR_LEN      = 32;
    localparam logic TRUE           = 1'b1;
    localparam logic FALSE          = 1'b0;
    localparam int   LINE_BYTES     = 16;
    localparam int   WORDS_PER_LINE = 4;
    localparam int   OFF_W          = $clog2(LINE_BYTES);
    localparam int   WSEL_W         = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2
    } state_e;
endpackage

// File: rtl/icache_array.sv
// Line storage: valid bits (async clear), tags and one data bank per word slot.
// Reads are combinational by index; writes land on the rising edge.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = ADDR_W - INDEX_W - OFF_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INDEX_W-1:0]   i_index,
    input  logic [WSEL_W-1:0]    i_rd_word,
    output logic                 o_rd_valid,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic [INSTR_LEN-1:0] o_rd_data,
    input  logic                 i_word_we,
    input  logic [WSEL_W-1:0]    i_wr_word,
    input  logic [INSTR_LEN-1:0] i_wr_data,
    input  logic                 i_fill_done,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic                 i_inv
);
    localparam int NLINES = 1 << INDEX_W;

    logic [NLINES-1:0]    r_valid;
    logic [TAG_W-1:0]     r_tag [NLINES];
    logic [INSTR_LEN-1:0] w_bank_rd [WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_fill_done) begin
            r_valid[i_index] <= TRUE;
        end else if (i_inv) begin
            r_valid[i_index] <= FALSE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_done) begin
            r_tag[i_index] <= i_wr_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
            logic [INSTR_LEN-1:0] r_bank [NLINES];

            always_ff @(posedge clk) begin
                if (i_word_we && (i_wr_word == WSEL_W'(gi))) begin
                    r_bank[i_index] <= i_wr_data;
                end
            end

            assign w_bank_rd[gi] = r_bank[i_index];
        end
    endgenerate

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];
    assign o_rd_data  = w_bank_rd[i_rd_word];
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: serves fetch requests, refills whole lines
// word 0..3 from the memory controller, and aborts cleanly on a mispredict flush.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_pc,
    output logic [INSTR_LEN-1:0] if_instr,
    output logic                 if_valid,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [INSTR_LEN-1:0] mem_rdata,
    input  logic                 mem_done
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;

    state_e                r_state, w_state_next;
    logic [ADDR_W-1:2]     r_req_pc, w_req_pc_next;
    logic [WSEL_W-1:0]     r_cnt, w_cnt_next;
    logic                  r_if_valid, w_if_valid_next;
    logic [INSTR_LEN-1:0]  r_if_instr, w_if_instr_next;
    logic                  r_mem_req, w_mem_req_next;
    logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_next;

    logic                  w_word_we, w_fill_done, w_inv;
    logic                  w_rd_valid, w_hit;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [INSTR_LEN-1:0]  w_rd_data;
    logic [1:0]            w_unused_pc_lsb;

    // Fetches are word aligned; the byte-offset bits carry no information.
    assign w_unused_pc_lsb = if_pc[1:0];

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_index     (r_req_pc[INDEX_W+OFF_W-1:OFF_W]),
        .i_rd_word   (r_req_pc[OFF_W-1:2]),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_word_we   (w_word_we & rdy),
        .i_wr_word   (r_cnt),
        .i_wr_data   (mem_rdata),
        .i_fill_done (w_fill_done & rdy),
        .i_wr_tag    (r_req_pc[ADDR_W-1:INDEX_W+OFF_W]),
        .i_inv       (w_inv & rdy)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == r_req_pc[ADDR_W-1:INDEX_W+OFF_W]);

    always_comb begin
        w_state_next    = r_state;
        w_req_pc_next   = r_req_pc;
        w_cnt_next      = r_cnt;
        w_if_valid_next = FALSE;
        w_if_instr_next = r_if_instr;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_word_we       = FALSE;
        w_fill_done     = FALSE;
        w_inv           = FALSE;

        // Flush overrides everything, including array writes this cycle.
        if (flush) begin
            w_state_next   = ST_IDLE;
            w_mem_req_next = FALSE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (if_req) begin
                        w_req_pc_next = if_pc[ADDR_W-1:2];
                        w_state_next  = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        w_if_instr_next = w_rd_data;
                        w_if_valid_next = TRUE;
                        w_state_next    = ST_IDLE;
                    end else begin
                        w_inv           = TRUE;
                        w_cnt_next      = '0;
                        w_mem_req_next  = TRUE;
                        w_mem_addr_next = {r_req_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        w_state_next    = ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_done) begin
                        w_word_we       = TRUE;
                        w_cnt_next      = r_cnt + WSEL_W'(1);
                        w_mem_addr_next = r_mem_addr + ADDR_W'(INSTR_LEN / 8);
                        if (r_cnt == WSEL_W'(WORDS_PER_LINE - 1)) begin
                            w_fill_done    = TRUE;
                            w_mem_req_next = FALSE;
                            w_state_next   = ST_LOOKUP;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_pc   <= '0;
            r_cnt      <= '0;
            r_if_valid <= FALSE;
            r_if_instr <= '0;
            r_mem_req  <= FALSE;
            r_mem_addr <= '0;
        end else if (rdy) begin
            r_state    <= w_state_next;
            r_req_pc   <= w_req_pc_next;
            r_cnt      <= w_cnt_next;
            r_if_valid <= w_if_valid_next;
            r_if_instr <= w_if_instr_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// checked against a line-level reference model and a behavioural memory.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        mem_done;
    logic        auto_done = 1'b0;
    logic        stray_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int mem_lat = 3;
    int mem_wait = 0;
    int log_base = 0;
    logic [31:0] addr_log[$];

    bit          mvalid [64];
    logic [21:0] mtag [64];

    assign mem_done = auto_done | stray_done;

    icache #(.INDEX_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush     (flush),
        .if_req    (if_req),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_valid  (if_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11;
            32'h104: return 32'h22;
            32'h108: return 32'h33;
            32'h10C: return 32'h44;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Memory controller: answers each word mem_lat cycles after it is requested.
    always @(negedge clk) begin
        auto_done = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (rst_n && rdy && mem_req) begin
            if (mem_wait >= mem_lat - 1) begin
                auto_done = 1'b1;
                mem_rdata = mem_word(mem_addr);
                addr_log.push_back(mem_addr);
                mem_wait = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
    end

    function automatic int exp_latency(input logic [31:0] pc);
        if (mvalid[pc[9:4]] && (mtag[pc[9:4]] == pc[31:10])) return 2;
        return 3 + 4 * mem_lat;
    endfunction

    function automatic void model_fill(input logic [31:0] pc);
        mvalid[pc[9:4]] = 1'b1;
        mtag[pc[9:4]] = pc[31:10];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, output logic [31:0] instr,
                         output int lat, output int extra, output int reqs);
        instr = '0;
        lat = -1;
        extra = 0;
        reqs = 0;
        log_base = addr_log.size();
        if_pc = pc;
        if_req = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (mem_req) reqs++;
            if (if_valid) begin
                instr = if_instr;
                lat = c;
                break;
            end
        end
        if_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (if_valid) extra++;
            if (mem_req) reqs++;
        end
        $display("fetch pc=%08h instr=%08h lat=%0d words=%0d", pc, instr, lat,
                 addr_log.size() - log_base);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%08h exp=0", if_instr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%08h exp=0", mem_addr); end
        rst_n = 1'b1;
        model_reset();
        step();
        $display("reset released");
    endtask

    task automatic test_cold_miss();
        logic [31:0] instr;
        int lat, extra, reqs;
        mem_lat = 3;
        fetch(32'h100, instr, lat, extra, reqs);
        checks++; if (lat != 15) begin failures++; $display("FAIL cold_latency got=%0d exp=15", lat); end
        checks++; if (instr !== 32'h11) begin failures++; $display("FAIL cold_instr got=%08h exp=00000011", instr); end
        checks++; if (extra != 0) begin failures++; $display("FAIL cold_pulse_width extra=%0d exp=0", extra); end
        checks++;
        if (addr_log.size() - log_base != 4) begin
            failures++; $display("FAIL cold_words got=%0d exp=4", addr_log.size() - log_base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addr_log[log_base + k] !== 32'h100 + 32'(4 * k)) begin
                    failures++; $display("FAIL cold_addr%0d got=%08h exp=%08h", k, addr_log[log_base + k], 32'h100 + 32'(4 * k));
                end
            end
        end
        model_fill(32'h100);
    endtask

    task automatic test_hit();
        logic [31:0] instr;
        int lat, extra, reqs;
        fetch(32'h108, instr, lat, extra, reqs);
        checks++; if (lat != 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
        checks++; if (instr !== 32'h33) begin failures++; $display("FAIL hit_instr got=%08h exp=00000033", instr); end
        checks++; if (reqs != 0) begin failures++; $display("FAIL hit_mem_req cycles=%0d exp=0", reqs); end
        checks++; if (extra != 0) begin failures++; $display("FAIL hit_pulse_width extra=%0d exp=0", extra); end
    endtask

    task automatic test_conflict();
        logic [31:0] instr;
        int lat, extra, reqs;
        fetch(32'h500, instr, lat, extra, reqs);
        checks++; if (lat != 15) begin failures++; $display("FAIL conflict_latency got=%0d exp=15", lat); end
        checks++; if (instr !== mem_word(32'h500)) begin failures++; $display("FAIL conflict_instr got=%08h exp=%08h", instr, mem_word(32'h500)); end
        checks++;
        if (addr_log.size() - log_base != 4) begin
            failures++; $display("FAIL conflict_words got=%0d exp=4", addr_log.size() - log_base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addr_log[log_base + k] !== 32'h500 + 32'(4 * k)) begin
                    failures++; $display("FAIL conflict_addr%0d got=%08h exp=%08h", k, addr_log[log_base + k], 32'h500 + 32'(4 * k));
                end
            end
        end
        model_fill(32'h500);
        fetch(32'h100, instr, lat, extra, reqs);
        checks++; if (lat != 15) begin failures++; $display("FAIL conflict_evict_latency got=%0d exp=15", lat); end
        checks++; if (instr !== 32'h11) begin failures++; $display("FAIL conflict_evict_instr got=%08h exp=00000011", instr); end
        model_fill(32'h100);
    endtask

    task automatic test_flush_refill();
        logic [31:0] instr;
        int lat, extra, reqs, seen_valid, seen_req;
        bit reached;
        fetch(32'h504, instr, lat, extra, reqs);
        checks++; if (instr !== mem_word(32'h504)) begin failures++; $display("FAIL flushref_setup_instr got=%08h exp=%08h", instr, mem_word(32'h504)); end
        model_fill(32'h504);
        log_base = addr_log.size();
        if_pc = 32'h100;
        if_req = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (addr_log.size() - log_base == 2) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin failures++; $display("FAIL flushref_second_word not reached"); end
        step();
        flush = 1'b1;
        if_req = 1'b0;
        step();
        flush = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL flushref_mem_req got=%0b exp=0", mem_req); end
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        seen_valid = 0;
        seen_req = 0;
        for (int c = 0; c < 5; c++) begin
            if (if_valid) seen_valid++;
            if (mem_req) seen_req++;
            step();
        end
        checks++; if (seen_valid != 0) begin failures++; $display("FAIL flushref_if_valid pulses=%0d exp=0", seen_valid); end
        checks++; if (seen_req != 0) begin failures++; $display("FAIL flushref_stray_req cycles=%0d exp=0", seen_req); end
        checks++; if (addr_log.size() - log_base != 2) begin failures++; $display("FAIL flushref_reads got=%0d exp=2", addr_log.size() - log_base); end
        $display("flush mid-refill applied, stray mem_done driven");
        mvalid[6'h10] = 1'b0;
        fetch(32'h100, instr, lat, extra, reqs);
        checks++; if (lat != exp_latency(32'h100) || lat != 15) begin failures++; $display("FAIL flushref_rerequest_latency got=%0d exp=15", lat); end
        checks++; if (instr !== 32'h11) begin failures++; $display("FAIL flushref_rerequest_instr got=%08h exp=00000011", instr); end
        checks++;
        if (addr_log.size() - log_base != 4) begin
            failures++; $display("FAIL flushref_rerequest_words got=%0d exp=4", addr_log.size() - log_base);
        end else if (addr_log[log_base] !== 32'h100 || addr_log[log_base + 3] !== 32'h10C) begin
            failures++; $display("FAIL flushref_rerequest_addr got=%08h..%08h exp=00000100..0000010c", addr_log[log_base], addr_log[log_base + 3]);
        end
        model_fill(32'h100);
    endtask

    task automatic test_flush_lookup();
        logic [31:0] instr;
        int lat, extra, reqs, seen_valid, seen_req;
        if_pc = 32'h104;
        if_req = 1'b1;
        step();
        flush = 1'b1;
        if_req = 1'b0;
        step();
        flush = 1'b0;
        seen_valid = 0;
        seen_req = 0;
        for (int c = 0; c < 4; c++) begin
            if (if_valid) seen_valid++;
            if (mem_req) seen_req++;
            step();
        end
        checks++; if (seen_valid != 0) begin failures++; $display("FAIL flushlk_if_valid pulses=%0d exp=0", seen_valid); end
        checks++; if (seen_req != 0) begin failures++; $display("FAIL flushlk_mem_req cycles=%0d exp=0", seen_req); end
        $display("flush coincident with lookup hit applied");
        fetch(32'h104, instr, lat, extra, reqs);
        checks++; if (lat != 2) begin failures++; $display("FAIL flushlk_after_latency got=%0d exp=2", lat); end
        checks++; if (instr !== 32'h22) begin failures++; $display("FAIL flushlk_after_instr got=%08h exp=00000022", instr); end
    endtask

    task automatic test_flush_idle();
        int seen_valid, seen_req;
        if_pc = 32'h900;
        if_req = 1'b1;
        flush = 1'b1;
        step();
        if_req = 1'b0;
        flush = 1'b0;
        seen_valid = 0;
        seen_req = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (if_valid) seen_valid++;
            if (mem_req) seen_req++;
        end
        checks++; if (seen_req != 0) begin failures++; $display("FAIL flushidle_latched mem_req cycles=%0d exp=0", seen_req); end
        checks++; if (seen_valid != 0) begin failures++; $display("FAIL flushidle_if_valid pulses=%0d exp=0", seen_valid); end
        $display("flush coincident with idle request applied");
    endtask

    task automatic test_rdy_freeze();
        bit reached, got;
        logic [31:0] instr;
        mem_lat = 3;
        log_base = addr_log.size();
        if_pc = 32'h500;
        if_req = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (addr_log.size() - log_base == 1) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin failures++; $display("FAIL rdy_first_word not reached"); end
        step();
        rdy = 1'b0;
        checks++; if (mem_addr !== 32'h504) begin failures++; $display("FAIL rdy_addr_before got=%08h exp=00000504", mem_addr); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (mem_addr !== 32'h504 || mem_req !== 1'b1 || if_valid !== 1'b0) begin
                failures++; $display("FAIL rdy_freeze_c%0d addr=%08h req=%0b valid=%0b exp=00000504/1/0", c, mem_addr, mem_req, if_valid);
            end
        end
        rdy = 1'b1;
        got = 1'b0;
        instr = '0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (if_valid) begin got = 1'b1; instr = if_instr; break; end
        end
        if_req = 1'b0;
        step();
        $display("rdy freeze fetch pc=00000500 instr=%08h words=%0d", instr, addr_log.size() - log_base);
        checks++; if (!got || instr !== mem_word(32'h500)) begin failures++; $display("FAIL rdy_instr got=%08h valid=%0b exp=%08h", instr, got, mem_word(32'h500)); end
        checks++;
        if (addr_log.size() - log_base != 4) begin
            failures++; $display("FAIL rdy_words got=%0d exp=4", addr_log.size() - log_base);
        end else if (addr_log[log_base + 1] !== 32'h504 || addr_log[log_base + 3] !== 32'h50C) begin
            failures++; $display("FAIL rdy_addr_order got=%08h,%08h exp=00000504,0000050c", addr_log[log_base + 1], addr_log[log_base + 3]);
        end
        model_fill(32'h500);
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] instr;
        int lat, extra, reqs;
        bit reached;
        mem_lat = 3;
        fetch(32'h108, instr, lat, extra, reqs);
        checks++; if (lat != 15 || instr !== 32'h33) begin failures++; $display("FAIL rstmid_setup lat=%0d instr=%08h exp=15/00000033", lat, instr); end
        model_fill(32'h108);
        log_base = addr_log.size();
        if_pc = 32'h200;
        if_req = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (addr_log.size() - log_base == 2) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin failures++; $display("FAIL rstmid_second_word not reached"); end
        rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL rstmid_clear valid=%0b instr=%08h req=%0b addr=%08h exp=0/0/0/0", if_valid, if_instr, mem_req, mem_addr);
        end
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        $display("async reset pulsed mid-refill");
        fetch(32'h108, instr, lat, extra, reqs);
        checks++; if (lat != 15) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=15", lat); end
        checks++; if (instr !== 32'h33) begin failures++; $display("FAIL rstmid_after_instr got=%08h exp=00000033", instr); end
        model_fill(32'h108);
        fetch(32'h200, instr, lat, extra, reqs);
        checks++; if (addr_log.size() - log_base != 4) begin failures++; $display("FAIL rstmid_partial_words got=%0d exp=4", addr_log.size() - log_base); end
        checks++; if (instr !== mem_word(32'h200)) begin failures++; $display("FAIL rstmid_partial_instr got=%08h exp=%08h", instr, mem_word(32'h200)); end
        model_fill(32'h200);
    endtask

    task automatic test_random();
        logic [31:0] pc, instr, exp_instr, base;
        logic [5:0]  idx_tab [4];
        int lat, extra, reqs, exp_lat, exp_words;
        idx_tab[0] = 6'h03;
        idx_tab[1] = 6'h07;
        idx_tab[2] = 6'h10;
        idx_tab[3] = 6'h20;
        for (int n = 0; n < 40; n++) begin
            pc = {20'h0, 2'($urandom_range(0, 2)), idx_tab[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'b00};
            mem_lat = $urandom_range(1, 4);
            exp_lat = exp_latency(pc);
            exp_words = (exp_lat == 2) ? 0 : 4;
            exp_instr = mem_word(pc);
            base = {pc[31:4], 4'h0};
            fetch(pc, instr, lat, extra, reqs);
            checks++; if (instr !== exp_instr) begin failures++; $display("FAIL rand%0d_instr pc=%08h got=%08h exp=%08h", n, pc, instr, exp_instr); end
            checks++; if (lat != exp_lat) begin failures++; $display("FAIL rand%0d_latency pc=%08h got=%0d exp=%0d", n, pc, lat, exp_lat); end
            checks++;
            if (addr_log.size() - log_base != exp_words) begin
                failures++; $display("FAIL rand%0d_words pc=%08h got=%0d exp=%0d", n, pc, addr_log.size() - log_base, exp_words);
            end else if (exp_words == 4 && (addr_log[log_base] !== base || addr_log[log_base + 3] !== base + 32'hC)) begin
                failures++; $display("FAIL rand%0d_addr pc=%08h got=%08h exp=%08h", n, pc, addr_log[log_base], base);
            end
            checks++; if (extra != 0) begin failures++; $display("FAIL rand%0d_pulse_width extra=%0d exp=0", n, extra); end
            model_fill(pc);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_flush_lookup();
        test_flush_idle();
        test_rdy_freeze();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
